y86_mem_arbiter: RTL and testbench

- Shares the single asynchronous-read memory port between the y86_seq core and a secondary DMA/debug requester.
- The core has absolute priority and is never stalled; it has no wait input and samples read data combinationally in its fetch and load phases.
- DMA requests are queued and issued only in cycles where the core is not using the bus.
- Read responses are returned over a valid/ready handshake. Usage statistics are kept.

---
 rtl/y86_mem_pkg.sv | 21 ++
 rtl/y86_req_fifo.sv | 60 ++++++
 rtl/y86_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_y86_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the y86 memory arbiter: default bus widths and the
// DMA request record that travels through the request FIFO.
package y86_mem_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  // One queued DMA request at the default widths; the FIFO stores the same
  // fields flattened as {we, addr, wdata} so non-default widths also work.
  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;

  // Bits needed to hold one flattened request.
  function automatic int unsigned req_bits(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/y86_req_fifo.sv
// DMA request queue: power-of-two ring buffer with a registered occupancy
// count. Full/empty come from the registered count only, so a pop never makes
// room for a push in the same cycle.
module y86_req_fifo
  import y86_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = req_bits(AW_DEF, DW_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/y86_mem_arbiter.sv
// Shares the single async-read memory port between the y86_seq core and a
// DMA/debug requester. The core always wins and sees zero added latency; DMA
// requests are queued and slipped into cycles where the core leaves the bus.
module y86_mem_arbiter
  import y86_mem_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    core_A,
  input  logic             core_RE,
  input  logic             core_WE,
  input  logic [DW-1:0]    core_wdata,
  output logic [DW-1:0]    core_rdata,
  input  logic             dma_req_valid,
  output logic             dma_req_ready,
  input  logic             dma_req_we,
  input  logic [AW-1:0]    dma_req_addr,
  input  logic [DW-1:0]    dma_req_wdata,
  output logic             dma_rsp_valid,
  input  logic             dma_rsp_ready,
  output logic [DW-1:0]    dma_rsp_rdata,
  output logic [AW-1:0]    mem_A,
  output logic             mem_RE,
  output logic             mem_WE,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             err_collision,
  output logic [CNT_W-1:0] stat_dma_cnt,
  output logic [CNT_W-1:0] stat_wait_cnt
);

  localparam int unsigned RW = req_bits(AW, DW);

  logic          w_core_act;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_issue;
  logic          w_rd_issue;
  logic          w_rsp_take;
  logic [RW-1:0] w_push_data;
  logic [RW-1:0] w_head;
  logic          w_head_we;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_wdata;

  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_data;
  logic [CNT_W-1:0] r_stat_dma;
  logic [CNT_W-1:0] r_stat_wait;
  logic             r_err;

  assign w_push_data  = {dma_req_we, dma_req_addr, dma_req_wdata};
  assign w_head_we    = w_head[RW-1];
  assign w_head_addr  = w_head[AW+DW-1:DW];
  assign w_head_wdata = w_head[DW-1:0];

  assign w_core_act    = core_RE | core_WE;
  assign dma_req_ready = !w_full;
  assign w_push        = dma_req_valid & !w_full;
  assign w_rsp_take    = r_rsp_valid & dma_rsp_ready;
  // A read head may only go out once the response slot is free or being
  // drained this cycle; writes never need the slot.
  assign w_issue       = !w_empty & !w_core_act & (w_head_we | !r_rsp_valid | w_rsp_take);
  assign w_rd_issue    = w_issue & !w_head_we;

  assign core_rdata    = mem_rdata;
  assign dma_rsp_valid = r_rsp_valid;
  assign dma_rsp_rdata = r_rsp_data;
  assign err_collision = r_err;
  assign stat_dma_cnt  = r_stat_dma;
  assign stat_wait_cnt = r_stat_wait;

  y86_req_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Memory port mux: core strobes pass straight through, DMA only on issue.
  always_comb begin
    mem_A     = '0;
    mem_RE    = 1'b0;
    mem_WE    = 1'b0;
    mem_wdata = '0;
    if (w_core_act) begin
      mem_A     = core_A;
      mem_RE    = core_RE;
      mem_WE    = core_WE;
      mem_wdata = core_wdata;
    end else if (w_issue) begin
      mem_A     = w_head_addr;
      mem_RE    = !w_head_we;
      mem_WE    = w_head_we;
      mem_wdata = w_head_wdata;
    end
  end

  // Response slot: capture read data on issue, hold until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_rd_issue) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= mem_rdata;
    end else if (w_rsp_take) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Saturating usage counters and the sticky core strobe collision flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_dma  <= '0;
      r_stat_wait <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_issue && (r_stat_dma != '1)) begin
        r_stat_dma <= r_stat_dma + CNT_W'(1);
      end
      if (!w_empty && w_core_act && (r_stat_wait != '1)) begin
        r_stat_wait <= r_stat_wait + CNT_W'(1);
      end
      if (core_RE && core_WE) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Bench for y86_mem_arbiter: directed stimulus, a queue-level reference model
// checked every cycle on the falling edge, plus hand-computed spot checks.
module tb_y86_mem_arbiter;
  import y86_mem_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] core_A;
  logic        core_RE;
  logic        core_WE;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        dma_req_valid;
  logic        dma_req_ready;
  logic        dma_req_we;
  logic [31:0] dma_req_addr;
  logic [31:0] dma_req_wdata;
  logic        dma_rsp_valid;
  logic        dma_rsp_ready;
  logic [31:0] dma_rsp_rdata;
  logic [31:0] mem_A;
  logic        mem_RE;
  logic        mem_WE;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        err_collision;
  logic [15:0] stat_dma_cnt;
  logic [15:0] stat_wait_cnt;

  int n_checks = 0;
  int n_errors = 0;

  y86_mem_arbiter #(
    .AW    (32),
    .DW    (32),
    .DEPTH (DEPTH),
    .CNT_W (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_A        (core_A),
    .core_RE       (core_RE),
    .core_WE       (core_WE),
    .core_wdata    (core_wdata),
    .core_rdata    (core_rdata),
    .dma_req_valid (dma_req_valid),
    .dma_req_ready (dma_req_ready),
    .dma_req_we    (dma_req_we),
    .dma_req_addr  (dma_req_addr),
    .dma_req_wdata (dma_req_wdata),
    .dma_rsp_valid (dma_rsp_valid),
    .dma_rsp_ready (dma_rsp_ready),
    .dma_rsp_rdata (dma_rsp_rdata),
    .mem_A         (mem_A),
    .mem_RE        (mem_RE),
    .mem_WE        (mem_WE),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .err_collision (err_collision),
    .stat_dma_cnt  (stat_dma_cnt),
    .stat_wait_cnt (stat_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory driven by the DUT's port (async read, sync write).
  logic [31:0] bmem [256];
  assign mem_rdata = bmem[mem_A[7:0]];
  always @(posedge clk) begin
    if (mem_WE) bmem[mem_A[7:0]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: request queue, response slot, counters, own memory copy.
  req_t        mq[$];
  logic [31:0] mmem [256];
  logic        m_rsp_valid;
  logic [31:0] m_rsp_data;
  int          m_dma_cnt;
  int          m_wait_cnt;
  logic        m_err;
  req_t        m_head;
  req_t        m_new;
  logic        m_core_act;
  logic        m_issue;
  logic        m_ready;
  logic [31:0] e_A;
  logic        e_RE;
  logic        e_WE;
  logic [31:0] e_wd;

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      m_rsp_valid = 1'b0;
      m_rsp_data  = '0;
      m_dma_cnt   = 0;
      m_wait_cnt  = 0;
      m_err       = 1'b0;
      chk("rst_rsp_valid", dma_rsp_valid, 0);
      chk("rst_req_ready", dma_req_ready, 1);
      chk("rst_mem_WE", mem_WE, 0);
      chk("rst_stat_dma", stat_dma_cnt, 0);
      chk("rst_err", err_collision, 0);
    end else begin
      m_core_act = core_RE | core_WE;
      m_ready    = (mq.size() < DEPTH);
      m_issue    = 1'b0;
      if (mq.size() > 0) begin
        m_head  = mq[0];
        m_issue = !m_core_act && (m_head.we || !m_rsp_valid || dma_rsp_ready);
      end
      e_A = '0; e_RE = 1'b0; e_WE = 1'b0; e_wd = '0;
      if (m_core_act) begin
        e_A = core_A; e_RE = core_RE; e_WE = core_WE; e_wd = core_wdata;
      end else if (m_issue) begin
        e_A = m_head.addr; e_RE = !m_head.we; e_WE = m_head.we; e_wd = m_head.wdata;
      end
      chk("mem_A", mem_A, e_A);
      chk("mem_RE", mem_RE, e_RE);
      chk("mem_WE", mem_WE, e_WE);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("core_rdata", core_rdata, mmem[e_A[7:0]]);
      chk("req_ready", dma_req_ready, m_ready);
      chk("rsp_valid", dma_rsp_valid, m_rsp_valid);
      if (m_rsp_valid) chk("rsp_rdata", dma_rsp_rdata, m_rsp_data);
      chk("stat_dma", stat_dma_cnt, m_dma_cnt);
      chk("stat_wait", stat_wait_cnt, m_wait_cnt);
      chk("err", err_collision, m_err);
      // Advance model to the state after the coming rising edge.
      if (mq.size() > 0 && m_core_act) m_wait_cnt++;
      if (core_RE && core_WE) m_err = 1'b1;
      if (m_issue) begin
        void'(mq.pop_front());
        m_dma_cnt++;
        if (!m_head.we) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = mmem[m_head.addr[7:0]];
        end else begin
          mmem[m_head.addr[7:0]] = m_head.wdata;
        end
      end
      if (!(m_issue && !m_head.we) && m_rsp_valid && dma_rsp_ready) m_rsp_valid = 1'b0;
      if (core_WE) mmem[core_A[7:0]] = core_wdata;
      if (dma_req_valid && m_ready) begin
        m_new.we    = dma_req_we;
        m_new.addr  = dma_req_addr;
        m_new.wdata = dma_req_wdata;
        mq.push_back(m_new);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic dma_set(input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req_valid = 1'b1;
    dma_req_we    = we;
    dma_req_addr  = a;
    dma_req_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 32'hA500_0000 | i;
      mmem[i] = 32'hA500_0000 | i;
    end
    bmem[8'h10] = 32'hDEAD_BEEF;
    mmem[8'h10] = 32'hDEAD_BEEF;
    rst = 1'b0;
    core_A = '0; core_RE = 1'b0; core_WE = 1'b0; core_wdata = '0;
    dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
    dma_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick;

    // Idle core: single DMA read.
    dma_set(1'b0, 32'h10, 32'h0);
    tick;
    dma_req_valid = 1'b0;
    #3 chk("t1_mem_RE", mem_RE, 1);
    chk("t1_mem_A", mem_A, 32'h10);
    tick;
    #3 chk("t1_rsp_valid", dma_rsp_valid, 1);
    chk("t1_rsp_rdata", dma_rsp_rdata, 32'hDEAD_BEEF);
    chk("t1_stat_dma", stat_dma_cnt, 1);
    tick;

    // Core busy three cycles holds off a queued DMA write.
    dma_set(1'b1, 32'h20, 32'h55);
    tick;
    dma_req_valid = 1'b0;
    core_RE = 1'b1; core_A = 32'h0;
    #3 chk("t2_core_rdata", core_rdata, 32'hA500_0000);
    chk("t2_held_WE", mem_WE, 0);
    repeat (3) tick;
    core_RE = 1'b0;
    #3 chk("t2_stat_wait", stat_wait_cnt, 3);
    chk("t2_mem_WE", mem_WE, 1);
    chk("t2_mem_A", mem_A, 32'h20);
    tick;

    // Fill the FIFO while the core is busy; fifth push waits for a free slot.
    core_RE = 1'b1; core_A = 32'h4;
    for (int i = 0; i < 4; i++) begin
      dma_set(1'b1, 32'h30 + 32'(4 * i), 32'h100 + 32'(i));
      tick;
    end
    dma_set(1'b1, 32'h44, 32'h104);
    #3 chk("t3_full_ready", dma_req_ready, 0);
    tick;
    core_RE = 1'b0;
    #3 chk("t3_pop_ready", dma_req_ready, 0);
    chk("t3_first_A", mem_A, 32'h30);
    tick;
    #3 chk("t3_ready_again", dma_req_ready, 1);
    chk("t3_second_A", mem_A, 32'h34);
    tick;
    dma_req_valid = 1'b0;
    repeat (6) tick;
    chk("t3_last_write", bmem[8'h44], 32'h104);

    // Stalled response blocks the next read until accepted.
    dma_rsp_ready = 1'b0;
    dma_set(1'b0, 32'h10, 32'h0);
    tick;
    dma_set(1'b0, 32'h40, 32'h0);
    tick;
    dma_req_valid = 1'b0;
    #3 chk("t4_blocked_RE", mem_RE, 0);
    chk("t4_rsp_valid", dma_rsp_valid, 1);
    chk("t4_rsp_hold", dma_rsp_rdata, 32'hDEAD_BEEF);
    tick;
    #3 chk("t4_rsp_stable", dma_rsp_rdata, 32'hDEAD_BEEF);
    tick;
    dma_rsp_ready = 1'b1;
    #3 chk("t4_b2b_RE", mem_RE, 1);
    chk("t4_b2b_A", mem_A, 32'h40);
    tick;
    #3 chk("t4_rsp2_valid", dma_rsp_valid, 1);
    chk("t4_rsp2_rdata", dma_rsp_rdata, 32'hA500_0040);
    tick;

    // Asynchronous reset with three writes queued.
    core_RE = 1'b1; core_A = 32'h0;
    for (int i = 0; i < 3; i++) begin
      dma_set(1'b1, 32'h50 + 32'(4 * i), 32'hBAD0 + 32'(i));
      tick;
    end
    dma_req_valid = 1'b0;
    core_RE = 1'b0;
    #2 rst = 1'b0;
    #1 chk("t5_async_rsp", dma_rsp_valid, 0);
    chk("t5_async_ready", dma_req_ready, 1);
    chk("t5_async_dma", stat_dma_cnt, 0);
    chk("t5_async_wait", stat_wait_cnt, 0);
    tick;
    tick;
    #1 rst = 1'b1;
    repeat (6) tick;
    chk("t5_no_write0", bmem[8'h50], 32'hA500_0050);
    chk("t5_no_write2", bmem[8'h58], 32'hA500_0058);
    chk("t5_dma_cnt", stat_dma_cnt, 0);

    // Strobe collision sets a sticky flag cleared only by reset.
    core_RE = 1'b1; core_WE = 1'b1; core_A = 32'h60; core_wdata = 32'h66;
    tick;
    core_RE = 1'b0; core_WE = 1'b0;
    #3 chk("t6_err_set", err_collision, 1);
    repeat (3) tick;
    chk("t6_err_sticky", err_collision, 1);
    rst = 1'b0;
    #1 chk("t6_err_clear", err_collision, 0);
    tick;
    tick;
    #1 rst = 1'b1;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
